// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: captures {pc, rd1, rd2, alu} per committed
// instruction in fill-once or ring mode, then drains oldest-first.
module commit_trace_buffer #(
  parameter  int XLEN  = 64,
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic            stop,
  input  logic            mode,
  input  logic            trig_en,
  input  logic [XLEN-1:0] trig_pc,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rd1,
  input  logic [XLEN-1:0] in_rd2,
  input  logic [XLEN-1:0] in_alu,
  input  logic            rd_ready,
  output logic            rd_valid,
  output logic [XLEN-1:0] rd_pc,
  output logic [XLEN-1:0] rd_rd1,
  output logic [XLEN-1:0] rd_rd2,
  output logic [XLEN-1:0] rd_alu,
  output logic [CW-1:0]   count,
  output logic            overflow,
  output logic [1:0]      state
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] alu;
  } entry_t;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            mode_q, mode_d;
  logic [XLEN-1:0] trig_pc_q, trig_pc_d;

  entry_t          mem [DEPTH];
  entry_t          wr_e;
  entry_t          rd_e;
  logic            we;
  logic            do_start;
  logic            out_en;

  assign wr_e     = '{pc: in_pc, rd1: in_rd1, rd2: in_rd2, alu: in_alu};
  assign do_start = start && (state_q == S_IDLE || state_q == S_DONE);
  assign out_en   = (state_q == S_DONE) && (count_q != '0);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    mode_d     = mode_q;
    trig_pc_d  = trig_pc_q;
    we         = 1'b0;

    if (do_start) begin
      // start wins over a same-cycle pop in DONE
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      mode_d     = mode;
      trig_pc_d  = trig_pc;
      state_d    = trig_en ? S_ARMED : S_CAPTURE;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_ARMED: begin
          if (in_valid && in_pc == trig_pc_q) begin
            we       = 1'b1;
            wr_ptr_d = AW'(1);
            count_d  = CW'(1);
            state_d  = S_CAPTURE;
          end
          if (stop) begin
            state_d  = S_DONE;
            rd_ptr_d = '0;
          end
        end
        S_CAPTURE: begin
          if (in_valid) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (count_q == FULL) overflow_d = 1'b1;
            else                 count_d    = count_q + CW'(1);
          end
          if (stop || (!mode_q && count_d == FULL)) begin
            state_d  = S_DONE;
            rd_ptr_d = overflow_d ? wr_ptr_d : '0;
          end
        end
        S_DONE: begin
          if (count_q == '0) begin
            state_d = S_IDLE;
          end else if (rd_ready) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            count_d  = count_q - CW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      mode_q     <= 1'b0;
      trig_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mode_q     <= mode_d;
      trig_pc_q  <= trig_pc_d;
    end
  end

  // storage contents are don't-care after reset, so no reset here
  always_ff @(posedge clock) begin
    if (we) mem[wr_ptr_q] <= wr_e;
  end

  assign rd_e     = out_en ? mem[rd_ptr_q] : '0;
  assign rd_valid = out_en;
  assign rd_pc    = rd_e.pc;
  assign rd_rd1   = rd_e.rd1;
  assign rd_rd2   = rd_e.rd2;
  assign rd_alu   = rd_e.alu;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign state    = state_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer, DEPTH=4, XLEN=64.
// Each scenario task drives stimulus and checks inline.
module tb_commit_trace_buffer;

  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic            mode = 1'b0;
  logic            trig_en = 1'b0;
  logic [XLEN-1:0] trig_pc = '0;
  logic            in_valid = 1'b0;
  logic [XLEN-1:0] in_pc = '0;
  logic [XLEN-1:0] in_rd1 = '0;
  logic [XLEN-1:0] in_rd2 = '0;
  logic [XLEN-1:0] in_alu = '0;
  logic            rd_ready = 1'b0;
  logic            rd_valid;
  logic [XLEN-1:0] rd_pc;
  logic [XLEN-1:0] rd_rd1;
  logic [XLEN-1:0] rd_rd2;
  logic [XLEN-1:0] rd_alu;
  logic [CW-1:0]   count;
  logic            overflow;
  logic [1:0]      state;

  int vectors = 0;
  int miscompares = 0;

  commit_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .trig_en  (trig_en),
    .trig_pc  (trig_pc),
    .in_valid (in_valid),
    .in_pc    (in_pc),
    .in_rd1   (in_rd1),
    .in_rd2   (in_rd2),
    .in_alu   (in_alu),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_pc    (rd_pc),
    .rd_rd1   (rd_rd1),
    .rd_rd2   (rd_rd2),
    .rd_alu   (rd_alu),
    .count    (count),
    .overflow (overflow),
    .state    (state)
  );

  always #5 clock = ~clock;

  function automatic logic [XLEN-1:0] f_rd1(input logic [XLEN-1:0] pc);
    return pc ^ 64'hDEAD_BEEF_0000_0000;
  endfunction
  function automatic logic [XLEN-1:0] f_rd2(input logic [XLEN-1:0] pc);
    return ~pc;
  endfunction
  function automatic logic [XLEN-1:0] f_alu(input logic [XLEN-1:0] pc);
    return pc + 64'h1234;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [XLEN-1:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_rd1   = f_rd1(pc);
    in_rd2   = f_rd2(pc);
    in_alu   = f_alu(pc);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic m, input logic te,
                             input logic [XLEN-1:0] tp);
    start   = 1'b1;
    mode    = m;
    trig_en = te;
    trig_pc = tp;
    tick();
    start   = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic expect_st(input string nm, input logic [1:0] s,
                           input logic [CW-1:0] c, input logic ov);
    vectors++;
    if (state !== s || count !== c || overflow !== ov) begin
      miscompares++;
      $display("FAIL %s: got state=%0d count=%0d ovf=%0b, want state=%0d count=%0d ovf=%0b",
               nm, state, count, overflow, s, c, ov);
    end
  endtask

  task automatic drain(input string nm, input logic [XLEN-1:0] base,
                       input int n);
    logic [XLEN-1:0] pc;
    for (int i = 0; i < n; i++) begin
      pc = base + XLEN'(4 * i);
      vectors++;
      if (rd_valid !== 1'b1 || rd_pc !== pc || rd_rd1 !== f_rd1(pc) ||
          rd_rd2 !== f_rd2(pc) || rd_alu !== f_alu(pc)) begin
        miscompares++;
        $display("FAIL %s[%0d]: got v=%0b pc=%h rd1=%h rd2=%h alu=%h, want pc=%h",
                 nm, i, rd_valid, rd_pc, rd_rd1, rd_rd2, rd_alu, pc);
      end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
    vectors++;
    if (rd_valid !== 1'b0 || count !== '0) begin
      miscompares++;
      $display("FAIL %s_empty: got v=%0b count=%0d, want v=0 count=0",
               nm, rd_valid, count);
    end
    tick();
    expect_st({nm, "_idle"}, 2'd0, '0, overflow);
  endtask

  task automatic test_reset();
    vectors++;
    if (state !== 2'd0 || count !== '0 || overflow !== 1'b0 ||
        rd_valid !== 1'b0 || rd_pc !== '0 || rd_alu !== '0) begin
      miscompares++;
      $display("FAIL reset: got state=%0d count=%0d ovf=%0b v=%0b pc=%h, want all 0",
               state, count, overflow, rd_valid, rd_pc);
    end
    pulse_stop();
    send(64'h99);
    expect_st("idle_ignores", 2'd0, '0, 1'b0);
  endtask

  task automatic test_fill();
    pulse_start(1'b0, 1'b0, '0);
    expect_st("fill_started", 2'd2, '0, 1'b0);
    send(0); send(4); send(8);
    expect_st("fill_3", 2'd2, 3'd3, 1'b0);
    send(12);
    expect_st("fill_full", 2'd3, 3'd4, 1'b0);
    send(16);
    expect_st("fill_ignore", 2'd3, 3'd4, 1'b0);
    drain("fill_drain", 0, 4);
  endtask

  task automatic test_ring();
    pulse_start(1'b1, 1'b0, '0);
    for (int i = 0; i < 6; i++) send(XLEN'(4 * i));
    expect_st("ring_cap", 2'd2, 3'd4, 1'b1);
    pulse_stop();
    expect_st("ring_done", 2'd3, 3'd4, 1'b1);
    drain("ring_drain", 8, 4);
  endtask

  task automatic test_trigger();
    pulse_start(1'b0, 1'b1, 64'd16);
    trig_pc = 64'd99;
    expect_st("trig_armed", 2'd1, '0, 1'b0);
    send(0); send(4); send(8); send(12);
    expect_st("trig_wait", 2'd1, '0, 1'b0);
    send(16);
    expect_st("trig_hit", 2'd2, 3'd1, 1'b0);
    send(20); send(24); send(28);
    expect_st("trig_full", 2'd3, 3'd4, 1'b0);
    drain("trig_drain", 16, 4);
  endtask

  task automatic test_backpressure();
    pulse_start(1'b1, 1'b0, '0);
    for (int i = 0; i < 6; i++) send(XLEN'(4 * i));
    pulse_stop();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (rd_valid !== 1'b1 || rd_pc !== 64'd8 || count !== 3'd4) begin
        miscompares++;
        $display("FAIL hold[%0d]: got v=%0b pc=%h count=%0d, want v=1 pc=8 count=4",
                 i, rd_valid, rd_pc, count);
      end
      tick();
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    vectors++;
    if (rd_pc !== 64'd12 || count !== 3'd3) begin
      miscompares++;
      $display("FAIL hold_pop: got pc=%h count=%0d, want pc=c count=3",
               rd_pc, count);
    end
    drain("hold_drain", 12, 3);
  endtask

  task automatic test_async_reset();
    pulse_start(1'b0, 1'b0, '0);
    send(0); send(4);
    expect_st("pre_reset", 2'd2, 3'd2, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (state !== 2'd0 || count !== '0 || rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got state=%0d count=%0d v=%0b, want 0 0 0",
               state, count, rd_valid);
    end
    reset_n = 1'b1;
    tick();
    pulse_start(1'b0, 1'b0, '0);
    send(40); send(44); send(48); send(52);
    expect_st("post_reset", 2'd3, 3'd4, 1'b0);
    drain("post_drain", 40, 4);
  endtask

  task automatic test_stop_restart();
    pulse_start(1'b0, 1'b0, '0);
    send(32); send(36);
    stop = 1'b1;
    send(40);
    stop = 1'b0;
    expect_st("stop_valid", 2'd3, 3'd3, 1'b0);
    drain("stop_drain", 32, 3);
    pulse_start(1'b0, 1'b0, '0);
    send(0); send(4);
    pulse_stop();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    vectors++;
    if (rd_pc !== 64'd4 || count !== 3'd1) begin
      miscompares++;
      $display("FAIL restart_pop: got pc=%h count=%0d, want pc=4 count=1",
               rd_pc, count);
    end
    start    = 1'b1;
    rd_ready = 1'b1;
    tick();
    start    = 1'b0;
    rd_ready = 1'b0;
    expect_st("restart", 2'd2, '0, 1'b0);
    vectors++;
    if (rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_valid: got %0b, want 0", rd_valid);
    end
    send(200);
    pulse_stop();
    expect_st("restart_done", 2'd3, 3'd1, 1'b0);
    drain("restart_drain", 200, 1);
  endtask

  task automatic test_armed_stop();
    pulse_start(1'b0, 1'b1, 64'd500);
    send(4);
    pulse_stop();
    expect_st("armed_stop", 2'd3, '0, 1'b0);
    vectors++;
    if (rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL armed_stop_valid: got %0b, want 0", rd_valid);
    end
    tick();
    expect_st("armed_idle", 2'd0, '0, 1'b0);
  endtask

  initial begin
    #12;
    test_reset();
    reset_n = 1'b1;
    tick();
    test_reset();
    test_fill();
    test_ring();
    test_trigger();
    test_backpressure();
    test_async_reset();
    test_stop_restart();
    test_armed_stop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
